wb_bus_arbiter: RTL

Two-master Wishbone arbiter and bus watchdog between the RS232 system controller master (port 0) and a second on-chip master such as the DAC waveform sequencer (port 1). It shares the single slave-side bus (DAC registers, memories) using round-robin grant with whole-cycle ownership. It drives the controller's bus-grant handshake and terminates hung slave accesses with a timeout error.

---
 rtl/wb_bus_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master round-robin Wishbone arbiter with bus watchdog
// Ports: clk_i/reset_i (async active-low); m0_* RS232 controller master with br/bg handshake;
// m1_* second master; s_* shared slave bus; m_dat_o read data broadcast to both masters;
// owner_o one-hot current owner {m1,m0}; timeout_o single-cycle watchdog expiry pulse.
module wb_bus_arbiter #(
   parameter int ADR_W   = 32,
   parameter int DAT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               m0_br_i,
   output logic               m0_bg_o,
   input  logic               m0_cyc_i,
   input  logic               m0_stb_i,
   input  logic               m0_we_i,
   input  logic [ADR_W-1:0]   m0_adr_i,
   input  logic [DAT_W-1:0]   m0_dat_i,
   input  logic [DAT_W/8-1:0] m0_sel_i,
   output logic               m0_ack_o,
   output logic               m0_err_o,
   input  logic               m1_cyc_i,
   input  logic               m1_stb_i,
   input  logic               m1_we_i,
   input  logic [ADR_W-1:0]   m1_adr_i,
   input  logic [DAT_W-1:0]   m1_dat_i,
   input  logic [DAT_W/8-1:0] m1_sel_i,
   output logic               m1_ack_o,
   output logic               m1_err_o,
   output logic [DAT_W-1:0]   m_dat_o,
   output logic               s_cyc_o,
   output logic               s_stb_o,
   output logic               s_we_o,
   output logic [ADR_W-1:0]   s_adr_o,
   output logic [DAT_W-1:0]   s_dat_o,
   output logic [DAT_W/8-1:0] s_sel_o,
   input  logic [DAT_W-1:0]   s_dat_i,
   input  logic               s_ack_i,
   input  logic               s_err_i,
   output logic [1:0]         owner_o,
   output logic               timeout_o
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
   state_t state, state_nxt;
   logic last;
   logic [CW-1:0] wd_cnt;
   logic req0, req1, own0, own1, pending, wd_err;
   assign req0 = m0_br_i | m0_cyc_i;
   assign req1 = m1_cyc_i;
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state == IDLE && state_nxt != IDLE) last <= (state_nxt == OWN1);
      end
   // Contention in IDLE goes to whichever master did not own the bus last.
   always_comb begin
      state_nxt = state;
      if (state == IDLE)
         state_nxt = (req0 & req1) ? (last ? OWN0 : OWN1) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
      else if (state == OWN0)
         state_nxt = req0 ? OWN0 : IDLE;
      else if (state == OWN1)
         state_nxt = req1 ? OWN1 : IDLE;
      else
         state_nxt = IDLE;
   end
   always_comb begin
      own0    = (state == OWN0);
      own1    = (state == OWN1);
      m0_bg_o = own0;
      owner_o = {own1, own0};
      s_cyc_o = own0 ? m0_cyc_i : own1 ? m1_cyc_i : 1'b0;
      s_stb_o = own0 ? m0_stb_i : own1 ? m1_stb_i : 1'b0;
      s_we_o  = own0 ? m0_we_i  : own1 ? m1_we_i  : 1'b0;
      s_adr_o = own0 ? m0_adr_i : own1 ? m1_adr_i : '0;
      s_dat_o = own0 ? m0_dat_i : own1 ? m1_dat_i : '0;
      s_sel_o = own0 ? m0_sel_i : own1 ? m1_sel_i : '0;
   end
   // A slave ack or err in the expiry cycle clears pending, so the real response wins.
   assign pending   = s_stb_o & ~s_ack_i & ~s_err_i;
   assign wd_err    = pending & (wd_cnt == CW'(TIMEOUT - 1));
   assign timeout_o = wd_err;
   always_ff @(posedge clk_i or negedge reset_i)
      if (!reset_i) wd_cnt <= '0;
      else          wd_cnt <= (!pending || wd_err) ? '0 : wd_cnt + 1'b1;
   assign m_dat_o  = s_dat_i;
   assign m0_ack_o = s_ack_i & own0;
   assign m1_ack_o = s_ack_i & own1;
   assign m0_err_o = (s_err_i | wd_err) & own0;
   assign m1_err_o = (s_err_i | wd_err) & own1;
endmodule
